// File: rtl/psg_bus_sched.sv
// Round-robin scheduler for the shared PSG register-write bus (CPU decode vs. dump player).
// Each write is an address-latch phase and a data phase, with a BDIR-low gap after each one.
module psg_bus_sched #(
    parameter int HOLD = 1,
    parameter int GAP  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_req,
    input  logic       cpu_chip,
    input  logic [3:0] cpu_reg,
    input  logic [7:0] cpu_data,
    output logic       cpu_ack,
    input  logic       ply_req,
    input  logic       ply_chip,
    input  logic [3:0] ply_reg,
    input  logic [7:0] ply_data,
    output logic       ply_ack,
    output logic [1:0] psg_bdir,
    output logic       psg_bc,
    output logic [7:0] psg_di,
    output logic       busy
);
    // state | meaning
    // IDLE  | arbitrate requests at each edge
    // ADDR  | BDIR high with BC=1, register number on DI
    // GAP_A | BDIR low after the address latch
    // DATA  | BDIR high with BC=0, value on DI
    // GAP_D | BDIR low after the data write, then back to IDLE
    typedef enum logic [2:0] {IDLE, ADDR, GAP_A, DATA, GAP_D} state_t;

    localparam logic [3:0] HOLD_LD = 4'(HOLD - 1);
    localparam logic [3:0] GAP_LD  = 4'(GAP - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic        chip;
    logic [7:0]  data;
    logic        last_ply;
    logic [1:0]  valid;
    logic [3:0]  last_addr [2];

    logic        grant_ply;
    logic        g_chip;
    logic [3:0]  g_reg;
    logic [7:0]  g_data;
    logic        skip;

    always_comb begin
        grant_ply = ply_req && (!cpu_req || !last_ply);
        g_chip    = grant_ply ? ply_chip : cpu_chip;
        g_reg     = grant_ply ? ply_reg  : cpu_reg;
        g_data    = grant_ply ? ply_data : cpu_data;
        skip      = valid[g_chip] && (last_addr[g_chip] == g_reg);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            chip         <= 1'b0;
            data         <= 8'h00;
            last_ply     <= 1'b1;
            valid        <= 2'b00;
            last_addr[0] <= 4'h0;
            last_addr[1] <= 4'h0;
            psg_bdir     <= 2'b00;
            psg_bc       <= 1'b0;
            psg_di       <= 8'h00;
            cpu_ack      <= 1'b0;
            ply_ack      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            ply_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req || ply_req) begin
                        chip     <= g_chip;
                        data     <= g_data;
                        last_ply <= grant_ply;
                        cpu_ack  <= !grant_ply;
                        ply_ack  <= grant_ply;
                        busy     <= 1'b1;
                        cnt      <= HOLD_LD;
                        psg_bdir <= g_chip ? 2'b10 : 2'b01;
                        // same register already latched in this chip: go straight to the data phase
                        if (skip) begin
                            state  <= DATA;
                            psg_bc <= 1'b0;
                            psg_di <= g_data;
                        end else begin
                            state             <= ADDR;
                            psg_bc            <= 1'b1;
                            psg_di            <= {4'h0, g_reg};
                            last_addr[g_chip] <= g_reg;
                            valid[g_chip]     <= 1'b1;
                        end
                    end
                end
                ADDR: begin
                    if (cnt == 4'd0) begin
                        state    <= GAP_A;
                        cnt      <= GAP_LD;
                        psg_bdir <= 2'b00;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                GAP_A: begin
                    if (cnt == 4'd0) begin
                        state    <= DATA;
                        cnt      <= HOLD_LD;
                        psg_bdir <= chip ? 2'b10 : 2'b01;
                        psg_bc   <= 1'b0;
                        psg_di   <= data;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DATA: begin
                    if (cnt == 4'd0) begin
                        state    <= GAP_D;
                        cnt      <= GAP_LD;
                        psg_bdir <= 2'b00;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                GAP_D: begin
                    if (cnt == 4'd0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
